// File: rtl/sram_io_pkg.sv
// Shared definitions for the serial SRAM I/O host: link control codes,
// phase kinds, per-phase and host state encodings, and width defaults.
package sram_io_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF  = 9;
    localparam int unsigned FRAME_WIDTH_DEF = ADDR_WIDTH_DEF + DATA_WIDTH_DEF;
    localparam int unsigned TIMEOUT_DEF     = 255;

    // CTRL codes seen by the SRAM I/O controller during a phase
    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_READ  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b11;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ACCESS,
        PH_UNLOAD
    } phase_kind_e;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_PRE,
        PS_ISSUE,
        PS_SHIFT,
        PS_WAIT
    } phase_state_e;

    typedef enum logic [1:0] {
        H_IDLE,
        H_RUN,
        H_DONE
    } host_state_e;

    // CTRL code for the SRAM access phase of a command
    function automatic logic [1:0] access_ctrl(input logic wr);
        return wr ? CTRL_WRITE : CTRL_READ;
    endfunction

endpackage

// File: rtl/sram_io_phase.sv
// One serial link phase (LOAD, ACCESS or UNLOAD): PRE, ISSUE, optional
// SHIFT of the frame LSB first, then WAIT for RDY.
// With SRAM_IO_HOST_TIMEOUT_EN defined, WAIT gives up after TIMEOUT_CYCLES.
module sram_io_phase import sram_io_pkg::*; #(
    parameter int unsigned MEMORY_DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned REG_BITS_WIDTH    = FRAME_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_DEF
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         start,
    input  logic [1:0]                   kind,
    input  logic [1:0]                   ctrl_code,
    input  logic [REG_BITS_WIDTH-1:0]    frame,
    input  logic                         SO,
    input  logic                         RDY,
    output logic                         BGN,
    output logic                         LOAD_N,
    output logic [1:0]                   CTRL,
    output logic                         SI,
    output logic                         done,
    output logic                         timeout,
    output logic [MEMORY_DATA_WIDTH-1:0] rbyte
);

    localparam int unsigned CNT_W = $clog2(REG_BITS_WIDTH + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(REG_BITS_WIDTH);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(MEMORY_DATA_WIDTH);

    phase_state_e              state;
    phase_kind_e               kind_q;
    logic [1:0]                ctrl_q;
    logic [REG_BITS_WIDTH-1:0] frame_q;
    logic [CNT_W-1:0]          cnt;

    assign done = (state == PS_WAIT) && (RDY || timeout);

    // Phase sequencer; link outputs are registered with the state.
    // cnt = 0 is the lead-in cycle, cnt = k drives frame bit k-1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= PS_IDLE;
            kind_q  <= PH_LOAD;
            ctrl_q  <= CTRL_LOAD;
            frame_q <= '0;
            cnt     <= '0;
            BGN     <= 1'b0;
            LOAD_N  <= 1'b1;
            CTRL    <= CTRL_LOAD;
            SI      <= 1'b0;
            rbyte   <= '0;
        end else if (start) begin
            // Accepted from IDLE or chained straight out of a completing WAIT
            state   <= PS_PRE;
            kind_q  <= phase_kind_e'(kind);
            ctrl_q  <= ctrl_code;
            frame_q <= frame;
            cnt     <= '0;
            BGN     <= 1'b0;
            LOAD_N  <= 1'b1;
            CTRL    <= CTRL_LOAD;
            SI      <= 1'b0;
        end else begin
            case (state)
                PS_IDLE: begin
                end
                PS_PRE: begin
                    state  <= PS_ISSUE;
                    BGN    <= 1'b1;
                    LOAD_N <= 1'b0;
                    CTRL   <= ctrl_q;
                end
                PS_ISSUE: begin
                    cnt <= '0;
                    if (kind_q == PH_ACCESS) begin
                        state <= PS_WAIT;
                        SI    <= 1'b0;
                    end else begin
                        state <= PS_SHIFT;
                        SI    <= frame_q[0];
                    end
                end
                PS_SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        state <= PS_WAIT;
                        SI    <= 1'b0;
                    end else begin
                        SI  <= frame_q[cnt];
                        cnt <= cnt + 1'b1;
                    end
                    // Read-back byte arrives LSB first; later samples are address bits
                    if (kind_q == PH_UNLOAD && cnt != '0 && cnt <= CAP_LAST) begin
                        rbyte <= {SO, rbyte[MEMORY_DATA_WIDTH-1:1]};
                    end
                end
                PS_WAIT: begin
                    if (done) begin
                        state  <= PS_IDLE;
                        BGN    <= 1'b0;
                        LOAD_N <= 1'b1;
                        CTRL   <= CTRL_LOAD;
                    end
                end
                default: state <= PS_IDLE;
            endcase
        end
    end

`ifdef SRAM_IO_HOST_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // Counts WAIT cycles without RDY; cleared whenever outside WAIT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (state == PS_WAIT && !RDY) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (state == PS_WAIT) && !RDY && (wait_cnt == WAIT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/sram_io_host.sv
// Host-side initiator for the serial SRAM I/O link. Turns REQ/ACK commands
// into LOAD/ACCESS(/UNLOAD) phases run by sram_io_phase.
// Optional macro SRAM_IO_HOST_TIMEOUT_EN enables the RDY timeout and ERR.
module sram_io_host import sram_io_pkg::*; #(
    parameter int unsigned MEMORY_DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MEMORY_ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_DEF
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         REQ,
    input  logic                         WR,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR,
    input  logic [MEMORY_DATA_WIDTH-1:0] WDATA,
    output logic                         ACK,
    output logic [MEMORY_DATA_WIDTH-1:0] RDATA,
    output logic                         BUSY,
    output logic                         ERR,
    output logic                         BGN,
    output logic                         LOAD_N,
    output logic [1:0]                   CTRL,
    output logic                         SI,
    input  logic                         SO,
    input  logic                         RDY
);

    host_state_e state;
    logic        wr_q;
    phase_kind_e phase_q;
    phase_kind_e next_phase;
    logic        more_phases;

    logic                         ph_start;
    logic [1:0]                   ph_kind;
    logic [1:0]                   ph_ctrl;
    logic [REG_BITS_WIDTH-1:0]    ph_frame;
    logic                         ph_done;
    logic                         ph_timeout;
    logic [MEMORY_DATA_WIDTH-1:0] ph_rbyte;

    // Which phase follows the current one and whether the command has one left
    always_comb begin
        next_phase  = PH_ACCESS;
        more_phases = 1'b0;
        case (phase_q)
            PH_LOAD: begin
                next_phase  = PH_ACCESS;
                more_phases = 1'b1;
            end
            PH_ACCESS: begin
                next_phase  = PH_UNLOAD;
                more_phases = !wr_q;
            end
            default: begin
                next_phase  = PH_UNLOAD;
                more_phases = 1'b0;
            end
        endcase
    end

    // Phase launch: LOAD at accept, later phases chained on the completing edge
    always_comb begin
        ph_start = 1'b0;
        ph_kind  = PH_LOAD;
        ph_ctrl  = CTRL_LOAD;
        ph_frame = '0;
        if (state == H_IDLE && REQ) begin
            ph_start = 1'b1;
            ph_frame = {ADDR, (WR ? WDATA : {MEMORY_DATA_WIDTH{1'b0}})};
        end else if (state == H_RUN && ph_done && !ph_timeout && more_phases) begin
            ph_start = 1'b1;
            ph_kind  = next_phase;
            if (next_phase == PH_ACCESS) begin
                ph_ctrl = access_ctrl(wr_q);
            end
        end
    end

    // Command handshake: accept, step through phases, one-cycle ACK
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= H_IDLE;
            wr_q    <= 1'b0;
            phase_q <= PH_LOAD;
            ACK     <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b0;
            RDATA   <= '0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (REQ) begin
                        state   <= H_RUN;
                        wr_q    <= WR;
                        phase_q <= PH_LOAD;
                        BUSY    <= 1'b1;
                        ERR     <= 1'b0;
                    end
                end
                H_RUN: begin
                    if (ph_done) begin
                        if (ph_timeout || !more_phases) begin
                            state <= H_DONE;
                            ACK   <= 1'b1;
                            BUSY  <= 1'b0;
                            ERR   <= ph_timeout;
                            if (!ph_timeout && phase_q == PH_UNLOAD) begin
                                RDATA <= ph_rbyte;
                            end
                        end else begin
                            phase_q <= next_phase;
                        end
                    end
                end
                H_DONE: begin
                    state <= H_IDLE;
                    ACK   <= 1'b0;
                end
                default: state <= H_IDLE;
            endcase
        end
    end

    sram_io_phase #(
        .MEMORY_DATA_WIDTH (MEMORY_DATA_WIDTH),
        .REG_BITS_WIDTH    (REG_BITS_WIDTH),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) u_phase (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (ph_start),
        .kind      (ph_kind),
        .ctrl_code (ph_ctrl),
        .frame     (ph_frame),
        .SO        (SO),
        .RDY       (RDY),
        .BGN       (BGN),
        .LOAD_N    (LOAD_N),
        .CTRL      (CTRL),
        .SI        (SI),
        .done      (ph_done),
        .timeout   (ph_timeout),
        .rbyte     (ph_rbyte)
    );

endmodule

// File: tb/tb_sram_io_host.sv
// Bench for sram_io_host: behavioural SRAM I/O controller plus SRAM,
// directed commands with a scoreboard checked on every ACK.
module tb_sram_io_host;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;
    logic       err;
    logic       bgn;
    logic       load_n;
    logic [1:0] ctrl;
    logic       si;
    logic       so;
    logic       rdy;

    sram_io_host dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .REQ    (req),
        .WR     (wr),
        .ADDR   (addr),
        .WDATA  (wdata),
        .ACK    (ack),
        .RDATA  (rdata),
        .BUSY   (busy),
        .ERR    (err),
        .BGN    (bgn),
        .LOAD_N (load_n),
        .CTRL   (ctrl),
        .SI     (si),
        .SO     (so),
        .RDY    (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- controller + SRAM model ----------------
    logic [7:0]  mem [512];
    logic [16:0] sr = '0;
    logic [16:0] load_bits = '0;
    int          k = 0;
    logic        rdy_q = 1'b0;
    logic        rdy_block = 1'b0;
    logic [1:0]  acc_ctrl = 2'b00;
    logic [8:0]  acc_addr = '0;
    logic [7:0]  acc_data = '0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h96;
    end

    assign so  = sr[0];
    assign rdy = rdy_q & ~rdy_block;

    always @(posedge clk) begin
        if (!bgn) begin
            k     <= 0;
            rdy_q <= 1'b0;
        end else if (!load_n) begin
            k <= k + 1;
            if (ctrl == 2'b00) begin
                if (k >= 2 && k <= 18) begin
                    sr        <= {si, sr[16:1]};
                    load_bits <= {si, load_bits[16:1]};
                end
                if (k == 18) rdy_q <= 1'b1;
            end else if (k == 0) begin
                acc_ctrl <= ctrl;
                acc_addr <= sr[16:8];
                acc_data <= sr[7:0];
                if (ctrl == 2'b11) mem[sr[16:8]] <= sr[7:0];
                else sr[7:0] <= mem[sr[16:8]];
                rdy_q <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   failed = 0;
    int   ack_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        tests++;
        if (act > lim) begin
            failed++;
            $display("FAIL %s: got %0d, limit %0d", name, act, lim);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ack) begin
            ack_count++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_ack: got ACK, expected none");
            end else begin
                e = exp_q.pop_front();
                check("ack_rdata", 32'(rdata), 32'(e.rdata));
                check("ack_err", 32'(err), 32'(e.err));
            end
        end
    end

    // Issue one command and wait for its ACK; REQ optionally left high.
    task automatic issue(input logic w, input logic [8:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_err, input bit keep,
                         input int exp_pre, output int lat);
        int  pre;
        bit  seen;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        wr = w; addr = a; wdata = d; req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                break;
            end
        end
        check("accept", 32'(seen), 32'd1);
        lat  = 0;
        pre  = (busy && !bgn) ? 1 : 0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            lat++;
            if (busy && !bgn) pre++;
            if (ack) begin
                seen = 1;
                break;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("pre_pulses", 32'(pre), 32'(exp_pre));
        if (!keep) req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    int         lat;
    int         n_cmds = 0;
    int         ack_before;
    logic [7:0] last_rd = 8'h00;

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bgn, load_n, ctrl, si, ack, busy, err, rdata}),
              32'({1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x0A5 <= 0x3C
        issue(1'b1, 9'h0A5, 8'h3C, last_rd, 1'b0, 0, 2, lat); n_cmds++;
        check_le("write_latency", lat, 50);
        check("sram_0a5", 32'(mem[9'h0A5]), 32'h3C);
        check("access_ctrl_addr_po", 32'({acc_ctrl, acc_addr, acc_data}),
              32'({2'b11, 9'h0A5, 8'h3C}));

        // Read back 0x0A5
        last_rd = 8'h3C;
        issue(1'b0, 9'h0A5, 8'h00, last_rd, 1'b0, 0, 3, lat); n_cmds++;
        check_le("read_latency", lat, 75);
        check("read_access_ctrl", 32'(acc_ctrl), 32'h1);

        // Back-to-back with REQ held high
        issue(1'b1, 9'h1FF, 8'hA5, last_rd, 1'b0, 1, 2, lat); n_cmds++;
        issue(1'b1, 9'h000, 8'h5A, last_rd, 1'b0, 1, 2, lat); n_cmds++;
        last_rd = 8'hA5;
        issue(1'b0, 9'h1FF, 8'h00, last_rd, 1'b0, 1, 3, lat); n_cmds++;
        last_rd = 8'h5A;
        issue(1'b0, 9'h000, 8'h00, last_rd, 1'b0, 0, 3, lat); n_cmds++;
        repeat (4) @(negedge clk);
        check("b2b_ack_count", 32'(ack_count), 32'(n_cmds));

        // Reset in the middle of a write's shift
        ack_before = ack_count;
        wr = 1'b1; addr = 9'h010; wdata = 8'h77; req = 1'b1;
        repeat (8) @(negedge clk);
        check("in_shift", 32'({busy, bgn, load_n}), 32'({1'b1, 1'b1, 1'b0}));
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({bgn, load_n, ctrl, si, ack, busy, err, rdata}),
              32'({1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("no_ack_after_reset", 32'(ack_count), 32'(ack_before));
        check("sram_010_kept", 32'(mem[9'h010]), 32'h86);
        last_rd = 8'h86;
        issue(1'b0, 9'h010, 8'h00, last_rd, 1'b0, 0, 3, lat); n_cmds++;

        // Frame order: {ADDR=0x100, WDATA=0x01} shifted LSB first
        issue(1'b1, 9'h100, 8'h01, last_rd, 1'b0, 0, 2, lat); n_cmds++;
        check("frame_bits", 32'(load_bits), 32'h10001);
        check("sram_100", 32'(mem[9'h100]), 32'h01);

`ifdef SRAM_IO_HOST_TIMEOUT_EN
        // RDY held low: LOAD times out, command ends with ERR
        rdy_block = 1'b1;
        issue(1'b0, 9'h001, 8'h00, last_rd, 1'b1, 0, 1, lat); n_cmds++;
        check("timeout_latency", 32'(lat), 32'(20 + 255));
        rdy_block = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b1, 9'h002, 8'h33, last_rd, 1'b0, 0, 2, lat); n_cmds++;
        check("sram_002", 32'(mem[9'h002]), 32'h33);
`endif

        repeat (4) @(negedge clk);
        check("total_acks", 32'(ack_count), 32'(n_cmds));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sram_io_host.md
Name: sram_io_host

Overview:
- Host-side initiator for the serial SRAM I/O link. It is the driving end of the BGN/SI/LOAD_N/CTRL/SO/RDY protocol used by the on-chip SRAM I/O controller.
- It accepts parallel write/read commands over a REQ/ACK handshake. Each command becomes a sequence of serial phases: address/data shift-in, SRAM access, and read-back shift-out.
- It sits in the test/debug wrapper between the scan/host logic and the SRAM I/O controller instance.

Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM word width.
- MEMORY_ADDR_WIDTH, 9, SRAM address width.
- REG_BITS_WIDTH, MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH, serial frame length (17).
- TIMEOUT_CYCLES, 255, maximum wait for RDY per phase (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  1  command request; held until ACK.
- WR  in  1  1 = write, 0 = read; sampled when REQ is accepted.
- ADDR  in  MEMORY_ADDR_WIDTH  target address; sampled when REQ is accepted.
- WDATA  in  MEMORY_DATA_WIDTH  write data; sampled when REQ is accepted.
- ACK  out  1  one-cycle pulse when the command completes.
- RDATA  out  MEMORY_DATA_WIDTH  read result; valid from ACK until the next read ACK.
- BUSY  out  1  high from REQ accept until ACK.
- ERR  out  1  set with ACK when a phase timed out (optional feature only; otherwise tied 0).
- BGN  out  1  link begin/reset toward the controller; low = reset controller.
- LOAD_N  out  1  phase start, active low.
- CTRL  out  2  00 = serial load, 01 = SRAM read, 11 = SRAM write.
- SI  out  1  serial data toward the controller.
- SO  in  1  serial data from the controller.
- RDY  in  1  controller phase-complete flag.

Behaviour:
- Reset: BGN=0, LOAD_N=1, CTRL=00, SI=0, ACK=0, BUSY=0, ERR=0, RDATA=0, FSM=IDLE.
- Command capture: in IDLE, REQ=1 latches WR/ADDR/WDATA and sets BUSY=1 on the next cycle. REQ is ignored while BUSY.

Phase sequence:
- Write: LOAD(frame = {ADDR, WDATA}), then ACCESS(CTRL=11).
- Read: LOAD(frame = {ADDR, 8'h00}), then ACCESS(CTRL=01), then UNLOAD(CTRL=00, frame = all zero, SO captured).

Per-phase FSM: PRE -> ISSUE -> (SHIFT) -> WAIT_RDY -> next phase or DONE.
- PRE: 1 cycle with BGN=0 and LOAD_N=1. This resets the controller's state and counter; its shift register is preserved, which carries data across phases.
- ISSUE: 1 cycle with BGN=1, LOAD_N=0 and CTRL driven. Call the closing edge E0.
- SHIFT (LOAD/UNLOAD only):
  - Frame bit i (i = 0..REG_BITS_WIDTH-1, LSB first: data bits 0..7, then address bits 0..8) is driven on SI in the cycle ending at edge E(2+i).
  - The cycle ending at E1 drives SI = bit 0 as lead-in.
  - In UNLOAD, SO is sampled at E(2+i) for i = 0..7 into RDATA bit i. Samples 8..16 are discarded.
  - LOAD_N stays 0 and CTRL stays fixed throughout.
- WAIT_RDY: LOAD_N held 0, CTRL held, SI=0. Advance when RDY=1 is sampled.
- DONE: 1 cycle with ACK=1, BUSY drops the same cycle, BGN returns to 0, LOAD_N=1. Then IDLE.
- RDATA updates only at the read DONE; a write leaves it unchanged.
- Reset asserted mid-command: immediate return to reset values; the command is dropped with no ACK.
- RDY arriving early (before SHIFT ends) is ignored; RDY is only evaluated in WAIT_RDY.
- Latency bounds (REQ accepted to ACK): write ≤ 50 cycles, read ≤ 75 cycles.

Optional Feature:
- Macro: SRAM_IO_HOST_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT_RDY. After TIMEOUT_CYCLES cycles without RDY, the FSM aborts the remaining phases and goes to DONE with ERR=1 alongside ACK. RDATA is unchanged on abort. ERR clears at the next REQ accept.
- Undefined: WAIT_RDY waits indefinitely and ERR is constant 0.

Decomposition:
- Package sram_io_pkg holds:
  - CTRL codes CTRL_LOAD=2'b00, CTRL_READ=2'b01, CTRL_WRITE=2'b11.
  - Phase encoding PH_LOAD, PH_ACCESS, PH_UNLOAD.
  - Per-phase state encoding.
  - Frame width and data/address width defaults.
- Sub-module sram_io_phase executes one phase: inputs kind, CTRL, frame; outputs done, captured byte. sram_io_host sequences the phases and owns the REQ/ACK handshake.

Test Plan:
- Bench pairs the host with the SRAM I/O controller and a behavioural SRAM.
- Write ADDR=9'h0A5, WDATA=8'h3C -> one ACK pulse, ERR=0. SRAM[0x0A5]=8'h3C; during ACCESS, CTRL=11 and the controller's A=0x0A5 and PO=0x3C.
- Read back ADDR=9'h0A5 -> ACK with RDATA=8'h3C. Three PRE pulses of BGN are observed. ACK arrives ≤ 75 cycles after accept.
- Back-to-back: write 0x1FF/0xA5, write 0x000/0x5A, read 0x1FF, read 0x000 (REQ held continuously) -> RDATA 0xA5 then 0x5A; REQ asserted while BUSY causes no extra ACK.
- RST_N pulsed low during the SHIFT of a write to 0x010 -> outputs at reset values immediately, no ACK, SRAM[0x010] unchanged. A subsequent read of 0x010 returns the prior contents.
- With SRAM_IO_HOST_TIMEOUT_EN and RDY forced 0: read 0x001 -> ACK with ERR=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_RDY; RDATA unchanged. Next normal command clears ERR.
- Frame order check: write ADDR=9'h100, WDATA=8'h01 -> SI shows bit0=1, bits 1..15=0, bit16=1 at edges E2..E18.
